// File: rtl/camera_pkg.sv
// Shared types and constants for the camera pixel packer.
// Holds the FSM state encoding and the packing-mode constants.
package camera_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } pack_state_e;

   localparam logic       PACK_HALF       = 1'b0;
   localparam logic       PACK_BYTE       = 1'b1;
   localparam logic [2:0] PACK_WORD_BYTES = 3'd4;

   // Index of the slot that completes a word: 1 in halfword mode, 3 in byte mode.
   function automatic logic [1:0] last_slot(input logic bytemode);
      return (bytemode == PACK_BYTE) ? 2'd3 : 2'd1;
   endfunction

endpackage

// File: rtl/camera_pack_stats.sv
// Pixel and word counters for the camera packer (built only with CAMERA_PACK_STATS_EN).
// Both counters wrap naturally; a clear request wins over a same-cycle increment.
module camera_pack_stats
   import camera_pkg::*;
#(
   parameter int CNT_WIDTH = 24
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 clr_i,
   input  logic                 pix_inc_i,
   input  logic                 word_inc_i,
   output logic [CNT_WIDTH-1:0] stat_pix_o,
   output logic [CNT_WIDTH-1:0] stat_words_o
);

   logic [CNT_WIDTH-1:0] pix_q, pix_d;
   logic [CNT_WIDTH-1:0] words_q, words_d;

   always_comb begin
      pix_d   = pix_q;
      words_d = words_q;
      if (clr_i) begin
         pix_d   = '0;
         words_d = '0;
      end else begin
         if (pix_inc_i)  pix_d   = pix_q + 1'b1;
         if (word_inc_i) words_d = words_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         pix_q   <= '0;
         words_q <= '0;
      end else begin
         pix_q   <= pix_d;
         words_q <= words_d;
      end
   end

   assign stat_pix_o   = pix_q;
   assign stat_words_o = words_q;

endmodule

// File: rtl/camera_pix_packer.sv
// Packs 16-bit (or 8-bit) camera samples into 32-bit words with flush of partial words.
// Optional counters are enabled with the CAMERA_PACK_STATS_EN macro.
module camera_pix_packer
   import camera_pkg::*;
#(
   parameter int CNT_WIDTH    = 24,
   parameter bit FLUSH_ON_DIS = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 cfg_en_i,
   input  logic                 cfg_bytemode_i,
   input  logic                 cfg_swap_i,
   input  logic                 flush_i,
   input  logic [15:0]          in_data_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [31:0]          out_data_o,
   output logic [2:0]           out_bytes_o,
   output logic                 out_last_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 flush_done_o,
   output logic [CNT_WIDTH-1:0] stat_words_o,
   output logic [CNT_WIDTH-1:0] stat_pix_o
);

   // Both sides use valid/ready: a transfer happens on a clock edge where valid & ready
   // are both high; the producer holds its payload stable while valid & ~ready.

   pack_state_e state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        mode_q, mode_d;
   logic        swap_q, swap_d;
   logic [31:0] out_data_q, out_data_d;
   logic [2:0]  out_bytes_q, out_bytes_d;
   logic        out_last_q, out_last_d;
   logic        out_valid_q, out_valid_d;

   logic        in_ready;
   logic        flush_done;
   logic        pix_inc;
   logic        stats_clr;
   logic        out_fire;
   logic [1:0]  nm1;
   logic [1:0]  slot;
   logic [31:0] placed;

   assign out_fire = out_valid_q & out_ready_i;

   // Position the incoming sample inside the word according to slot and width.
   always_comb begin
      nm1  = last_slot(mode_q);
      slot = swap_q ? (nm1 - cnt_q) : cnt_q;
      if (mode_q == PACK_BYTE) placed = {24'd0, in_data_i[7:0]} << {slot, 3'b000};
      else                     placed = {16'd0, in_data_i} << {slot[0], 4'b0000};
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      swap_d      = swap_q;
      out_data_d  = out_data_q;
      out_bytes_d = out_bytes_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      in_ready    = 1'b0;
      flush_done  = 1'b0;
      pix_inc     = 1'b0;
      stats_clr   = 1'b0;

      if (out_fire) out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (cfg_en_i) begin
               state_d   = RUN;
               mode_d    = cfg_bytemode_i;
               swap_d    = cfg_swap_i;
               acc_d     = '0;
               cnt_d     = '0;
               stats_clr = 1'b1;
            end
         end

         RUN: begin
            // Only the word-completing slot needs the output register to be free.
            in_ready = (cnt_q != nm1) | ~out_valid_q | out_ready_i;
            if (in_valid_i && in_ready) begin
               pix_inc = 1'b1;
               if (cnt_q == nm1) begin
                  out_data_d  = acc_q | placed;
                  out_bytes_d = PACK_WORD_BYTES;
                  out_last_d  = 1'b0;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
               end else begin
                  acc_d = acc_q | placed;
                  cnt_d = cnt_q + 2'd1;
               end
            end
            if (!cfg_en_i) begin
               if (FLUSH_ON_DIS) begin
                  state_d = FLUSH;
               end else begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end else if (flush_i) begin
               state_d = FLUSH;
            end
         end

         FLUSH: begin
            if (cnt_q == 2'd0) begin
               flush_done = 1'b1;
               state_d    = cfg_en_i ? RUN : IDLE;
            end else if (!out_valid_q) begin
               out_data_d  = acc_q;
               out_bytes_d = (mode_q == PACK_BYTE) ? {1'b0, cnt_q} : {cnt_q, 1'b0};
               out_last_d  = 1'b1;
               out_valid_d = 1'b1;
               acc_d       = '0;
               cnt_d       = '0;
               flush_done  = 1'b1;
               state_d     = cfg_en_i ? RUN : IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= PACK_HALF;
         swap_q      <= 1'b0;
         out_data_q  <= '0;
         out_bytes_q <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         swap_q      <= swap_d;
         out_data_q  <= out_data_d;
         out_bytes_q <= out_bytes_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o   = in_ready;
   assign flush_done_o = flush_done;
   assign out_data_o   = out_data_q;
   assign out_bytes_o  = out_bytes_q;
   assign out_last_o   = out_last_q;
   assign out_valid_o  = out_valid_q;

`ifdef CAMERA_PACK_STATS_EN
   camera_pack_stats #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_stats (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .clr_i        (stats_clr),
      .pix_inc_i    (pix_inc),
      .word_inc_i   (out_fire),
      .stat_pix_o   (stat_pix_o),
      .stat_words_o (stat_words_o)
   );
`else
   logic unused_stats;
   assign unused_stats = ^{pix_inc, stats_clr};
   assign stat_pix_o   = '0;
   assign stat_words_o = '0;
`endif

endmodule
